// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch sequencer for a MIPS-style core.
// A BOOT/FETCH/ISSUE FSM selects the next PC and runs a ready/valid handshake with instruction memory.
module pc_fetch_unit #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_VEC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0]    EXC_VEC   = 32'h0000_0180,
  parameter int unsigned          INST_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [2:0]        PC_s,
  input  logic [ADDR_W-1:0] R_Data_A,
  input  logic [ADDR_W-1:0] imm_data,
  input  logic [25:0]       address,
  input  logic              exc_req,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] Inst_code,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] EPC,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [2:0] SEL_JR   = 3'b001;
  localparam logic [2:0] SEL_BR   = 3'b010;
  localparam logic [2:0] SEL_JMP  = 3'b011;
  localparam logic [2:0] SEL_ERET = 3'b100;

  // Jump keeps PC4 bits above 27; building the target with a mask also works when ADDR_W is exactly 28.
  localparam logic [ADDR_W-1:0] JMP_HI_MASK = ~ADDR_W'(28'hFFF_FFFF);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                addr_err_q, addr_err_d;

  logic [ADDR_W-1:0]   pc4;
  logic [ADDR_W-1:0]   jmp_target;
  logic [ADDR_W-1:0]   next_pc;
  logic                exc_take;
  logic                jr_misaligned;

  assign pc4        = pc_q + ADDR_W'(4);
  assign jmp_target = (pc4 & JMP_HI_MASK) | ADDR_W'({address, 2'b00});

  always_comb begin
    unique case (PC_s)
      SEL_JR:   next_pc = R_Data_A;
      SEL_BR:   next_pc = pc4 + (imm_data << 2);
      SEL_JMP:  next_pc = jmp_target;
      SEL_ERET: next_pc = epc_q;
      default:  next_pc = pc4;
    endcase
  end

  assign exc_take      = exc_req && (state_q != BOOT);
  assign jr_misaligned = (PC_s == SEL_JR) && (R_Data_A[1:0] != 2'b00);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    addr_err_d = 1'b0;

    unique case (state_q)
      BOOT: state_d = FETCH;

      FETCH: begin
        if (exc_take) begin
          epc_d   = pc_q;
          pc_d    = EXC_VEC;
          valid_d = 1'b0;
        end else if (imem_ready) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (exc_take) begin
          epc_d   = pc_q;
          pc_d    = EXC_VEC;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = FETCH;
          if (jr_misaligned) begin
            addr_err_d = 1'b1;
            epc_d      = pc_q;
            pc_d       = EXC_VEC;
          end else begin
            pc_d = next_pc;
          end
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Request decodes straight from state, so it falls as soon as reset forces BOOT.
  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign PC         = pc_q;
  assign EPC        = epc_q;
  assign Inst_code  = inst_q;
  assign inst_valid = valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a next-PC vector table plus hand-written
// sequences for wait states, stall, misaligned jr, exceptions and reset.
module tb_pc_fetch_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic [2:0]        PC_s;
  logic [31:0]       R_Data_A;
  logic [31:0]       imm_data;
  logic [25:0]       address;
  logic              exc_req;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic [31:0]       Inst_code;
  logic              inst_valid;
  logic [31:0]       PC;
  logic [31:0]       EPC;
  logic              addr_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  pc_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(32'h0000_0000),
    .EXC_VEC  (32'h0000_0180),
    .INST_W   (INST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .PC_s      (PC_s),
    .R_Data_A  (R_Data_A),
    .imm_data  (imm_data),
    .address   (address),
    .exc_req   (exc_req),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .Inst_code (Inst_code),
    .inst_valid(inst_valid),
    .PC        (PC),
    .EPC       (EPC),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  // Instruction memory model: each word is a recognisable function of its address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = inst_of(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  pc_s;
    logic [31:0] rda;
    logic [31:0] imm;
    logic [25:0] addr;
    logic [31:0] pc_before;
    logic [31:0] pc_after;
  } vec_t;

  vec_t vecs[13];

  // Entered in FETCH with zero-wait memory; runs one FETCH + ISSUE instruction.
  task automatic run_vec(input int i, input vec_t v);
    check($sformatf("v%0d fetch req", i), 32'(imem_req), 32'd1);
    check($sformatf("v%0d pc before", i), PC, v.pc_before);
    step();
    check($sformatf("v%0d issue valid", i), 32'(inst_valid), 32'd1);
    check($sformatf("v%0d issue inst", i), Inst_code, inst_of(v.pc_before));
    check($sformatf("v%0d issue no req", i), 32'(imem_req), 32'd0);
    PC_s = v.pc_s; R_Data_A = v.rda; imm_data = v.imm; address = v.addr;
    step();
    check($sformatf("v%0d pc after", i), PC, v.pc_after);
    check($sformatf("v%0d valid cleared", i), 32'(inst_valid), 32'd0);
    PC_s = 3'b000;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'h0,          32'h0,          26'h0,       32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{3'b000, 32'h0,          32'h0,          26'h0,       32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{3'b000, 32'h0,          32'h0,          26'h0,       32'h0000_0008, 32'h0000_000C};
    vecs[3]  = '{3'b001, 32'h0000_0040,  32'h0,          26'h0,       32'h0000_000C, 32'h0000_0040};
    vecs[4]  = '{3'b010, 32'h0,          32'hFFFF_FFFE,  26'h0,       32'h0000_0040, 32'h0000_003C};
    vecs[5]  = '{3'b001, 32'h1000_0010,  32'h0,          26'h0,       32'h0000_003C, 32'h1000_0010};
    vecs[6]  = '{3'b011, 32'h0,          32'h0,          26'h0000100, 32'h1000_0010, 32'h1000_0400};
    vecs[7]  = '{3'b111, 32'h0,          32'h0,          26'h0,       32'h1000_0400, 32'h1000_0404};
    vecs[8]  = '{3'b010, 32'h0,          32'h0000_0003,  26'h0,       32'h1000_0404, 32'h1000_0414};
    vecs[9]  = '{3'b001, 32'h0000_0020,  32'h0,          26'h0,       32'h1000_0414, 32'h0000_0020};
    vecs[10] = '{3'b001, 32'hFFFF_FFFC,  32'h0,          26'h0,       32'h0000_0020, 32'hFFFF_FFFC};
    vecs[11] = '{3'b000, 32'h0,          32'h0,          26'h0,       32'hFFFF_FFFC, 32'h0000_0000};
    vecs[12] = '{3'b001, 32'h0000_0020,  32'h0,          26'h0,       32'h0000_0000, 32'h0000_0020};

    rst = 1'b0; stall = 1'b0; PC_s = 3'b000; R_Data_A = '0; imm_data = '0;
    address = '0; exc_req = 1'b0; imem_ready = 1'b1;
    #12;
    check("reset PC", PC, 32'h0);
    check("reset EPC", EPC, 32'h0);
    check("reset Inst_code", Inst_code, 32'h0);
    check("reset inst_valid", 32'(inst_valid), 32'd0);
    check("reset imem_req", 32'(imem_req), 32'd0);
    check("reset addr_err", 32'(addr_err), 32'd0);
    rst = 1'b1;
    step();
    check("boot exit PC", PC, 32'h0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Three wait states at PC 0x20: request held four cycles, nothing latched early.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wait%0d req", i), 32'(imem_req), 32'd1);
      check($sformatf("wait%0d addr", i), imem_addr, 32'h0000_0020);
      check($sformatf("wait%0d inst held", i), Inst_code, inst_of(32'h0));
      step();
    end
    check("wait3 req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    step();
    check("wait done inst", Inst_code, inst_of(32'h20));
    check("wait done valid", 32'(inst_valid), 32'd1);

    // Stall five cycles in ISSUE.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall%0d PC", i), PC, 32'h0000_0020);
      check($sformatf("stall%0d inst", i), Inst_code, inst_of(32'h20));
      check($sformatf("stall%0d no req", i), 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    step();
    check("stall release PC", PC, 32'h0000_0024);
    check("stall release req", 32'(imem_req), 32'd1);
    step();

    // Return to 0x20, then a misaligned jr.
    PC_s = 3'b001; R_Data_A = 32'h0000_0020;
    step();
    step();
    check("jr setup PC", PC, 32'h0000_0020);
    R_Data_A = 32'h0000_0102;
    step();
    check("misalign addr_err", 32'(addr_err), 32'd1);
    check("misalign EPC", EPC, 32'h0000_0020);
    check("misalign PC", PC, 32'h0000_0180);
    PC_s = 3'b000;
    step();
    check("addr_err one cycle", 32'(addr_err), 32'd0);
    check("handler inst", Inst_code, inst_of(32'h180));
    PC_s = 3'b100;
    step();
    check("eret PC", PC, 32'h0000_0020);
    PC_s = 3'b000;

    // Exception during a FETCH wait at 0x44 with imem_ready high in the same cycle.
    step();
    PC_s = 3'b001; R_Data_A = 32'h0000_0044;
    step();
    PC_s = 3'b000;
    check("exc setup PC", PC, 32'h0000_0044);
    imem_ready = 1'b0;
    step();
    exc_req = 1'b1; imem_ready = 1'b1;
    step();
    exc_req = 1'b0;
    check("fetch exc EPC", EPC, 32'h0000_0044);
    check("fetch exc PC", PC, 32'h0000_0180);
    check("fetch exc valid", 32'(inst_valid), 32'd0);
    check("fetch exc not latched", Inst_code, inst_of(32'h20));
    check("fetch exc refetch", 32'(imem_req), 32'd1);
    step();
    check("handler2 inst", Inst_code, inst_of(32'h180));

    // exc_req with eret and stall in ISSUE: exception wins, EPC overwritten.
    PC_s = 3'b100; stall = 1'b1; exc_req = 1'b1;
    step();
    PC_s = 3'b000; stall = 1'b0; exc_req = 1'b0;
    check("exc+eret EPC", EPC, 32'h0000_0180);
    check("exc+eret PC", PC, 32'h0000_0180);
    check("exc+eret valid", 32'(inst_valid), 32'd0);

    // Reset mid-fetch, then exc_req during BOOT is ignored.
    imem_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("async rst req", 32'(imem_req), 32'd0);
    check("async rst PC", PC, 32'h0);
    check("async rst EPC", EPC, 32'h0);
    check("async rst inst", Inst_code, 32'h0);
    rst = 1'b1; exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    check("boot exc PC", PC, 32'h0);
    check("boot exc EPC", EPC, 32'h0);
    check("boot exc req", 32'(imem_req), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
